// File: rtl/palette_color_lut_if.sv
// Pixel, palette-write and blink signals between the pixel mux and the palette LUT.
interface palette_color_lut_if #(
    parameter int CODE_W  = 4,
    parameter int COLOR_W = 8
);
    logic [CODE_W-1:0]  pix_code;
    logic               video_on;
    logic               wr_en;
    logic [CODE_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               frame_tick;
    logic               blink_en;
    logic [CODE_W-1:0]  blink_code;
    logic [COLOR_W-1:0] color_out;
    logic               color_valid;

    modport master (
        output pix_code, video_on,
        output wr_en, wr_addr, wr_data,
        output frame_tick, blink_en, blink_code,
        input  color_out, color_valid
    );

    modport slave (
        input  pix_code, video_on,
        input  wr_en, wr_addr, wr_data,
        input  frame_tick, blink_en, blink_code,
        output color_out, color_valid
    );
endinterface

// File: rtl/palette_color_lut.sv
// Writable colour palette with frame-synchronous blink, 2-cycle registered path.
module palette_color_lut #(
    parameter int CODE_W       = 4,
    parameter int COLOR_W      = 8,
    parameter int BLINK_FRAMES = 30
) (
    input logic clk,
    input logic reset,
    palette_color_lut_if.slave bus
);
    localparam int DEPTH = 1 << CODE_W;
    localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

    logic [COLOR_W-1:0] pal [DEPTH];

    logic [7:0]        blink_cnt;
    logic              blink_phase;

    logic [CODE_W-1:0] s1_code;
    logic              s1_video;
    logic              s1_hit;

    logic              hit;
    logic [COLOR_W-1:0] entry;

    function automatic logic [COLOR_W-1:0] def_color(input int idx);
        logic [7:0] v;
        case (idx)
            10:      v = 8'hE0;
            11:      v = 8'hF3;
            12:      v = 8'hF7;
            13:      v = 8'h2F;
            14:      v = 8'h57;
            15:      v = 8'h55;
            default: v = 8'hE0;
        endcase
        return COLOR_W'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                pal[i] <= def_color(i);
        end else if (bus.wr_en) begin
            pal[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Disabling blink parks the phase on the visible half.
    always_ff @(posedge clk) begin
        if (reset || !bus.blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_tick) begin
            if (blink_cnt == LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    assign hit = bus.blink_en & blink_phase &
                 (bus.pix_code == bus.blink_code);

    // A write landing on the entry S1 is about to read wins.
    always_comb begin
        entry = pal[s1_code];
        if (bus.wr_en && (bus.wr_addr == s1_code))
            entry = bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_code         <= '0;
            s1_video        <= 1'b0;
            s1_hit          <= 1'b0;
            bus.color_out   <= '0;
            bus.color_valid <= 1'b0;
        end else begin
            s1_code         <= bus.pix_code;
            s1_video        <= bus.video_on;
            s1_hit          <= hit;
            bus.color_valid <= s1_video;
            if (!s1_video || s1_hit)
                bus.color_out <= '0;
            else
                bus.color_out <= entry;
        end
    end
endmodule
